window_generator: RTL and testbench
===================================

// Module: window_generator
// PURPOSE
//  Converts a raster-order pixel stream into 3x3 neighbourhoods for the convolver.
//  Two line buffers plus a 3x3 register window present all nine pixels each cycle.
//  Sits directly upstream of the convolver; o_subframe1..9 wire to its subframe1..9.
// PARAMETERS
//  NB_DATA     8    pixel width in bits
//  IMG_WIDTH   64   pixels per line (>=3)
//  IMG_HEIGHT  64   lines per frame (>=3)
// PORTS
//  i_clk          in   1        clock, rising edge
//  i_reset        in   1        asynchronous, active-low reset
//  i_valid        in   1        i_pixel valid this cycle
//  i_sof          in   1        start of frame; qualified by i_valid, marks pixel (0,0)
//  i_pixel        in   NB_DATA  input pixel, raster order
//  o_subframe1..9 out  NB_DATA  window, row-major: 1=top-left, 5=centre, 9=bottom-right
//  o_valid        out  1        o_subframe1..9 hold a complete window
//  o_frame_done   out  1        one-cycle pulse with the last window of a frame
// BEHAVIOUR
//  - Reset (i_reset=0): state IDLE, col=row=0, o_valid=0, o_frame_done=0,
//    window regs and o_subframe* = 0. Line-buffer RAMs not reset (masked by o_valid).
//  - FSM IDLE: i_valid&!i_sof pixels dropped; i_valid&i_sof -> ACTIVE, pixel accepted as (0,0).
//  - FSM ACTIVE: every i_valid pixel accepted. i_sof&i_valid mid-frame aborts the current
//    frame: pixel taken as (0,0), no o_frame_done for the aborted frame.
//  - Counters: col 0..IMG_WIDTH-1, row 0..IMG_HEIGHT-1; after accepting (H-1,W-1) both
//    wrap to 0 and the FSM stays ACTIVE, so the next pixel is (0,0) even without i_sof.
//  - Accepted pixel at column c: top=LB1[c], mid=LB0[c], bot=i_pixel;
//    LB1[c]<=LB0[c]; LB0[c]<=i_pixel. Window shifts one column left; new column = top/mid/bot.
//  - Latency 1 cycle: window and outputs update on the edge that accepts the pixel.
//    o_valid=1 on the next cycle iff that pixel had row>=2 and col>=2.
//  - o_frame_done=1 together with o_valid for the window whose newest pixel is (H-1,W-1).
//  - Row boundaries: windows with col<2 straddle lines and are never flagged valid.
//  - Stall: i_valid=0 -> no state change; o_valid and o_frame_done drop to 0 next cycle;
//    o_subframe* hold their values.
//  - Outputs registered; o_subframe* hold between valid windows.
//  - Valid windows per frame = (IMG_WIDTH-2)*(IMG_HEIGHT-2).
//  - No backpressure: the downstream stage accepts one window per cycle.
//  - Line buffers: single-write, single-read RAM of IMG_WIDTH x NB_DATA each;
//    read and write at the same column address in the same cycle.
// TESTING (IMG_WIDTH=IMG_HEIGHT=4, pixel(r,c)=4r+c)
//  1 sof+16 back-to-back pixels -> exactly 4 o_valid windows; first = 0,1,2,4,5,6,8,9,10,
//    one cycle after pixel 10; last = 5,6,7,9,10,11,13,14,15 with o_frame_done=1.
//  2 same frame with i_valid low every other cycle -> identical 4 windows, o_valid never
//    in consecutive cycles, o_subframe* stable during gaps.
//  3 pixels without sof after reset -> no o_valid; a later sof frame behaves as test 1.
//  4 sof at pixel 9 of frame A, then full frame B (values +100) -> no frame_done for A;
//    B's first window = 100,101,102,104,105,106,108,109,110.
//  5 two frames back-to-back, sof only on the first -> 8 windows, 2 frame_done pulses.
//  6 i_reset=0 mid-frame -> outputs 0 asynchronously; no o_valid until a new sof frame.

Source files
------------

// File: rtl/window_generator_if.sv
// Pixel-in / 3x3-window-out bundle between the raster source, window_generator and the convolver.
interface window_generator_if #(
  parameter int NB_DATA = 8
);
  logic               i_valid;
  logic               i_sof;
  logic [NB_DATA-1:0] i_pixel;
  logic [NB_DATA-1:0] o_subframe1;
  logic [NB_DATA-1:0] o_subframe2;
  logic [NB_DATA-1:0] o_subframe3;
  logic [NB_DATA-1:0] o_subframe4;
  logic [NB_DATA-1:0] o_subframe5;
  logic [NB_DATA-1:0] o_subframe6;
  logic [NB_DATA-1:0] o_subframe7;
  logic [NB_DATA-1:0] o_subframe8;
  logic [NB_DATA-1:0] o_subframe9;
  logic               o_valid;
  logic               o_frame_done;

  modport master (
    output i_valid, i_sof, i_pixel,
    input  o_subframe1, o_subframe2, o_subframe3, o_subframe4, o_subframe5,
    input  o_subframe6, o_subframe7, o_subframe8, o_subframe9,
    input  o_valid, o_frame_done
  );

  modport slave (
    input  i_valid, i_sof, i_pixel,
    output o_subframe1, o_subframe2, o_subframe3, o_subframe4, o_subframe5,
    output o_subframe6, o_subframe7, o_subframe8, o_subframe9,
    output o_valid, o_frame_done
  );
endinterface

// File: rtl/window_generator.sv
// Raster pixel stream to 3x3 neighbourhood: two line buffers feed a shifting 3x3 register window.
//  state  | meaning
//  IDLE   | waiting for a start-of-frame pixel; other pixels are dropped
//  ACTIVE | every valid pixel is accepted; frames wrap back to (0,0) on their own
module window_generator #(
  parameter int NB_DATA    = 8,
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64
) (
  input logic              i_clk,
  input logic              i_reset,
  window_generator_if.slave bus
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t              state_q, state_d;
  logic                accept;
  logic [CW-1:0]       col_q, cur_col;
  logic [RW-1:0]       row_q, cur_row;
  logic [NB_DATA-1:0]  lb0 [IMG_WIDTH];
  logic [NB_DATA-1:0]  lb1 [IMG_WIDTH];
  logic [NB_DATA-1:0]  top, mid;
  logic [NB_DATA-1:0]  win [9];
  logic                valid_q, done_q;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.i_valid && bus.i_sof) begin
          accept  = 1'b1;
          state_d = ACTIVE;
        end
      end
      ACTIVE:  accept  = bus.i_valid;
      default: state_d = IDLE;
    endcase
  end

  // A start-of-frame pixel always lands at (0,0), even mid-frame.
  assign cur_col = bus.i_sof ? '0 : col_q;
  assign cur_row = bus.i_sof ? '0 : row_q;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      col_q <= '0;
      row_q <= '0;
    end else if (accept) begin
      if (cur_col == COL_LAST) begin
        col_q <= '0;
        row_q <= (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
      end else begin
        col_q <= cur_col + 1'b1;
        row_q <= cur_row;
      end
    end
  end

  // Line buffers are plain RAMs; stale contents never reach a valid window.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      lb1[cur_col] <= lb0[cur_col];
      lb0[cur_col] <= bus.i_pixel;
    end
  end

  assign top = lb1[cur_col];
  assign mid = lb0[cur_col];

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int k = 0; k < 9; k++) win[k] <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      valid_q <= accept && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
      done_q  <= accept && (cur_row == ROW_LAST) && (cur_col == COL_LAST);
      if (accept) begin
        win[0] <= win[1];  win[1] <= win[2];  win[2] <= top;
        win[3] <= win[4];  win[4] <= win[5];  win[5] <= mid;
        win[6] <= win[7];  win[7] <= win[8];  win[8] <= bus.i_pixel;
      end
    end
  end

  assign bus.o_subframe1  = win[0];
  assign bus.o_subframe2  = win[1];
  assign bus.o_subframe3  = win[2];
  assign bus.o_subframe4  = win[3];
  assign bus.o_subframe5  = win[4];
  assign bus.o_subframe6  = win[5];
  assign bus.o_subframe7  = win[6];
  assign bus.o_subframe8  = win[7];
  assign bus.o_subframe9  = win[8];
  assign bus.o_valid      = valid_q;
  assign bus.o_frame_done = done_q;
endmodule

// File: tb/tb_window_generator.sv
// Scoreboard bench for window_generator: a frame-image model predicts each valid 3x3 window.
module tb_window_generator;
  localparam int NB = 8;
  localparam int W  = 4;
  localparam int H  = 4;

  typedef struct packed {
    logic             done;
    logic [8:0][NB-1:0] w;
  } exp_t;

  logic i_clk = 1'b0;
  logic i_reset = 1'b0;
  always #5 i_clk = ~i_clk;

  window_generator_if #(.NB_DATA(NB)) bus ();

  window_generator #(.NB_DATA(NB), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .bus    (bus)
  );

  logic [NB-1:0] sf [9];
  assign sf[0] = bus.o_subframe1;
  assign sf[1] = bus.o_subframe2;
  assign sf[2] = bus.o_subframe3;
  assign sf[3] = bus.o_subframe4;
  assign sf[4] = bus.o_subframe5;
  assign sf[5] = bus.o_subframe6;
  assign sf[6] = bus.o_subframe7;
  assign sf[7] = bus.o_subframe8;
  assign sf[8] = bus.o_subframe9;

  exp_t          q[$];
  int            n_vec = 0;
  int            n_err = 0;
  int            done_seen = 0;
  int            done_exp = 0;
  logic          acc_now = 1'b0;
  bit            model_active = 0;
  int            mr = 0, mc = 0;
  logic [NB-1:0] img [H][W];

  // Behavioural model: remember the current frame as an image and emit the
  // 3x3 neighbourhood ending at every pixel with row>=2 and col>=2.
  task automatic drive(input logic v, input logic s, input logic [NB-1:0] p);
    exp_t e;
    logic acc;
    @(negedge i_clk);
    bus.i_valid = v;
    bus.i_sof   = s;
    bus.i_pixel = p;
    acc = v && (model_active || s);
    acc_now = acc;
    n_vec++;
    if (acc) begin
      if (s) begin mr = 0; mc = 0; end
      model_active = 1;
      img[mr][mc] = p;
      if (mr >= 2 && mc >= 2) begin
        for (int k = 0; k < 9; k++) e.w[k] = img[mr - 2 + k / 3][mc - 2 + k % 3];
        e.done = (mr == H - 1 && mc == W - 1);
        if (e.done) done_exp++;
        q.push_back(e);
      end
      mc++;
      if (mc == W) begin
        mc = 0;
        mr = (mr == H - 1) ? 0 : mr + 1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, NB'($urandom));
  endtask

  task automatic frame(input int base, input bit sof, input bit gaps);
    for (int i = 0; i < W * H; i++) begin
      drive(1'b1, sof && i == 0, NB'(base + i));
      if (gaps) drive(1'b0, 1'b0, NB'($urandom));
    end
  endtask

  task automatic check_zero(input string name);
    n_vec++;
    if (bus.o_valid !== 1'b0 || bus.o_frame_done !== 1'b0) begin
      n_err++;
      $display("FAIL %s flags: valid=%b done=%b required 0 0", name, bus.o_valid, bus.o_frame_done);
    end
    for (int k = 0; k < 9; k++)
      if (sf[k] !== '0) begin
        n_err++;
        $display("FAIL %s subframe%0d: got %0d required 0", name, k + 1, sf[k]);
      end
  endtask

  task automatic check_drained(input string name);
    idle(3);
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL %s pending windows: got %0d outstanding required 0", name, q.size());
      q.delete();
    end
    if (done_seen != done_exp) begin
      n_err++;
      $display("FAIL %s frame_done count: got %0d required %0d", name, done_seen, done_exp);
    end
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_reset = 1'b0;
    acc_now = 1'b0;
    model_active = 0;
    mr = 0;
    mc = 0;
    #1 check_zero("reset");
    @(negedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b1;
  endtask

  // Monitor: pops the scoreboard whenever the DUT flags a window.
  initial begin : monitor
    logic          acc_edge;
    logic [NB-1:0] last [9];
    bit            have_last;
    exp_t          e;
    have_last = 0;
    forever begin
      @(posedge i_clk);
      acc_edge = acc_now;
      #1;
      if (!i_reset) begin
        have_last = 0;
        continue;
      end
      if (bus.o_frame_done === 1'b1) done_seen++;
      if (bus.o_valid === 1'b1) begin
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL spurious_window: o_valid=1 required 0 (no window expected)");
        end else begin
          e = q.pop_front();
          for (int k = 0; k < 9; k++)
            if (sf[k] !== e.w[k]) begin
              n_err++;
              $display("FAIL window subframe%0d: got %0d required %0d", k + 1, sf[k], e.w[k]);
            end
          if (bus.o_frame_done !== e.done) begin
            n_err++;
            $display("FAIL frame_done: got %b required %b", bus.o_frame_done, e.done);
          end
        end
      end else begin
        if (bus.o_frame_done !== 1'b0) begin
          n_err++;
          $display("FAIL done_without_valid: got %b required 0", bus.o_frame_done);
        end
        if (!acc_edge && have_last)
          for (int k = 0; k < 9; k++)
            if (sf[k] !== last[k]) begin
              n_err++;
              $display("FAIL hold subframe%0d: got %0d required %0d", k + 1, sf[k], last[k]);
            end
      end
      for (int k = 0; k < 9; k++) last[k] = sf[k];
      have_last = 1;
    end
  end

  initial begin
    bus.i_valid = 1'b0;
    bus.i_sof   = 1'b0;
    bus.i_pixel = '0;
    #2 check_zero("power_on_reset");
    #20 i_reset = 1'b1;

    frame(0, 1, 0);
    check_drained("back_to_back");

    frame(0, 1, 1);
    check_drained("gapped");

    do_reset();
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, NB'(i));
    check_drained("no_sof");
    frame(0, 1, 0);
    check_drained("after_no_sof");

    for (int i = 0; i < 9; i++) drive(1'b1, i == 0, NB'(i));
    frame(100, 1, 0);
    check_drained("abort");

    frame(0, 1, 0);
    frame(50, 0, 0);
    check_drained("two_frames");

    for (int i = 0; i < 7; i++) drive(1'b1, i == 0, NB'(i));
    do_reset();
    for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, NB'(i));
    check_drained("reset_mid_frame");
    frame(30, 1, 0);
    check_drained("after_reset");

    for (int i = 0; i < 400; i++)
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0, NB'($urandom));
    check_drained("random");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
